// File: rtl/axi4_stream_rx.sv
// AXI4-Stream 32-bit sink: TDEST/TID filter, frame-length checking FSM and a
// first-word-fall-through FIFO feeding the downstream fabric consumer.
module axi4_stream_rx #(
  parameter int          FRAME_LEN  = 10,
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADDR_W     = 4,
  parameter logic [1:0]  DEST_MATCH = 2'd0,
  parameter logic [7:0]  ID_MATCH   = 8'd0
) (
  input  logic        ACLK,
  input  logic        RST,
  input  logic        TVALID,
  output logic        TREADY,
  input  logic [31:0] TDATA,
  input  logic        TLAST,
  input  logic [3:0]  TKEEP,
  input  logic [1:0]  TDEST,
  input  logic [7:0]  TID,
  output logic [31:0] DOUT,
  output logic        DOUT_LAST,
  output logic        DOUT_VALID,
  input  logic        DOUT_READY,
  input  logic        CLR_ERR,
  output logic [15:0] FRAME_CNT,
  output logic        ERR_EARLY,
  output logic        ERR_LATE,
  output logic        ERR_KEEP,
  output logic        BUSY
);

  localparam int              BEAT_W    = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FRAME = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              err_early_q, err_early_d;
  logic              err_late_q, err_late_d;
  logic              err_keep_q, err_keep_d;
  logic [32:0]       mem_q [FIFO_DEPTH];

  logic push_s, pop_s, match_s, not_empty_s;
  logic set_early_s, set_late_s, set_keep_s, good_s;
  logic [32:0] head_s;

  // TREADY comes from the registered count only, so TVALID never loops back into it.
  assign TREADY      = !RST && (count_q != FULL_CNT);
  assign not_empty_s = (count_q != {(ADDR_W + 1){1'b0}});
  assign match_s     = (TDEST == DEST_MATCH) && (TID == ID_MATCH);
  assign push_s      = TVALID && TREADY && match_s;
  assign pop_s       = DOUT_READY && not_empty_s;
  assign head_s      = mem_q[rd_ptr_q];

  assign DOUT       = not_empty_s ? head_s[31:0] : 32'h0000_0000;
  assign DOUT_LAST  = not_empty_s ? head_s[32] : 1'b0;
  assign DOUT_VALID = not_empty_s;
  assign FRAME_CNT  = frame_cnt_q;
  assign ERR_EARLY  = err_early_q;
  assign ERR_LATE   = err_late_q;
  assign ERR_KEEP   = err_keep_q;
  assign BUSY       = (state_q != ST_IDLE);

  // Framing FSM: tracks beat position of matching beats and flags length errors.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    set_early_s = 1'b0;
    set_late_s  = 1'b0;
    good_s      = 1'b0;
    if (push_s) begin
      case (state_q)
        ST_IDLE: begin
          if (TLAST) begin
            set_early_s = 1'b1;
          end else begin
            beat_d  = BEAT_W'(1'b1);
            state_d = ST_FRAME;
          end
        end
        ST_FRAME: begin
          if (TLAST) begin
            if (beat_q == LAST_BEAT) begin
              good_s = 1'b1;
            end else begin
              set_early_s = 1'b1;
            end
            beat_d  = {BEAT_W{1'b0}};
            state_d = ST_IDLE;
          end else if (beat_q == LAST_BEAT) begin
            set_late_s = 1'b1;
            state_d    = ST_DRAIN;
          end else begin
            beat_d = beat_q + BEAT_W'(1'b1);
          end
        end
        ST_DRAIN: begin
          if (TLAST) begin
            beat_d  = {BEAT_W{1'b0}};
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          beat_d  = {BEAT_W{1'b0}};
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FIFO pointers/occupancy, good-frame counter and sticky error flags (set wins over clear).
  always_comb begin
    set_keep_s  = push_s && (TKEEP != 4'hF) && (TKEEP != 4'h0);
    wr_ptr_d    = push_s ? (wr_ptr_q + ADDR_W'(1'b1)) : wr_ptr_q;
    rd_ptr_d    = pop_s ? (rd_ptr_q + ADDR_W'(1'b1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1'b1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1'b1);
      default: count_d = count_q;
    endcase
    frame_cnt_d = good_s ? (frame_cnt_q + 16'd1) : frame_cnt_q;
    err_early_d = set_early_s || (err_early_q && !CLR_ERR);
    err_late_d  = set_late_s || (err_late_q && !CLR_ERR);
    err_keep_d  = set_keep_s || (err_keep_q && !CLR_ERR);
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge ACLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      beat_q      <= {BEAT_W{1'b0}};
      wr_ptr_q    <= {ADDR_W{1'b0}};
      rd_ptr_q    <= {ADDR_W{1'b0}};
      count_q     <= {(ADDR_W + 1){1'b0}};
      frame_cnt_q <= 16'd0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
      err_keep_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      frame_cnt_q <= frame_cnt_d;
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
      err_keep_q  <= err_keep_d;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy count says empty.
  always_ff @(posedge ACLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {TLAST, TDATA};
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_axi4_stream_rx.sv
// Randomized self-checking bench for axi4_stream_rx against a queue-based
// reference model of the stream sink.
module tb_axi4_stream_rx;

  localparam int FRAME_LEN = 10;
  localparam int DEPTH     = 16;

  logic        clk = 1'b0;
  logic        rst, tvalid, tready, tlast, dout_last, dout_valid, dout_ready;
  logic        clr_err, err_early, err_late, err_keep, busy;
  logic [31:0] tdata, dout;
  logic [3:0]  tkeep;
  logic [1:0]  tdest;
  logic [7:0]  tid;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  axi4_stream_rx #(
    .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(DEPTH), .ADDR_W(4),
    .DEST_MATCH(2'd0), .ID_MATCH(8'd0)
  ) dut (
    .ACLK(clk), .RST(rst), .TVALID(tvalid), .TREADY(tready), .TDATA(tdata),
    .TLAST(tlast), .TKEEP(tkeep), .TDEST(tdest), .TID(tid), .DOUT(dout),
    .DOUT_LAST(dout_last), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
    .CLR_ERR(clr_err), .FRAME_CNT(frame_cnt), .ERR_EARLY(err_early),
    .ERR_LATE(err_late), .ERR_KEEP(err_keep), .BUSY(busy)
  );

  // Reference model state
  logic [32:0] m_q[$];
  logic [15:0] m_fcnt;
  bit          m_early, m_late, m_keep, m_drain;
  int          m_pos;

  int n_checks = 0;
  int n_errors = 0;
  bit last_acc;
  int rdy_pct  = 100;
  int frame_id = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: predict from current inputs, advance, then compare every output.
  task automatic tick();
    bit acc, match, s_e, s_l, s_k;
    logic [32:0] popped;
    acc   = tvalid && !rst && (m_q.size() != DEPTH);
    match = (tdest == 2'd0) && (tid == 8'd0);
    @(posedge clk);
    #1;
    s_e = 1'b0; s_l = 1'b0; s_k = 1'b0;
    if (rst) begin
      m_q.delete();
      m_fcnt = 16'd0; m_early = 1'b0; m_late = 1'b0; m_keep = 1'b0;
      m_drain = 1'b0; m_pos = 0;
      acc = 1'b0;
    end else begin
      if (acc && match) begin
        if (tkeep != 4'hF && tkeep != 4'h0) s_k = 1'b1;
        if (m_drain) begin
          if (tlast) begin m_drain = 1'b0; m_pos = 0; end
        end else if (tlast) begin
          if (m_pos == FRAME_LEN - 1) m_fcnt = m_fcnt + 16'd1;
          else s_e = 1'b1;
          m_pos = 0;
        end else if (m_pos == FRAME_LEN - 1) begin
          s_l = 1'b1; m_drain = 1'b1;
        end else begin
          m_pos++;
        end
      end
      if (dout_ready && m_q.size() > 0) popped = m_q.pop_front();
      if (acc && match) m_q.push_back({tlast, tdata});
      m_early = s_e || (m_early && !clr_err);
      m_late  = s_l || (m_late && !clr_err);
      m_keep  = s_k || (m_keep && !clr_err);
    end
    last_acc = acc;
    check_eq("tready", tready, !rst && (m_q.size() != DEPTH));
    check_eq("dout_valid", dout_valid, m_q.size() != 0);
    if (m_q.size() != 0) check_eq("dout_head", {dout_last, dout}, m_q[0]);
    if (rst) check_eq("rst_dout", {dout_last, dout}, 33'd0);
    check_eq("frame_cnt", frame_cnt, m_fcnt);
    check_eq("err_early", err_early, m_early);
    check_eq("err_late", err_late, m_late);
    check_eq("err_keep", err_keep, m_keep);
    check_eq("busy", busy, m_drain || (m_pos != 0));
  endtask

  task automatic idle(input int n, input bit rdy);
    tvalid = 1'b0; dout_ready = rdy;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one beat and hold it until the model says it was accepted.
  task automatic send_beat(input logic [31:0] d, input bit l, input logic [3:0] k,
                           input logic [1:0] dst, input logic [7:0] id);
    int tries = 0;
    tvalid = 1'b1; tdata = d; tlast = l; tkeep = k; tdest = dst; tid = id;
    do begin
      dout_ready = ($urandom_range(0, 99) < rdy_pct);
      tick();
      clr_err = 1'b0;
      tries++;
    end while (!last_acc && tries < 300);
    if (!last_acc) check_eq("beat_timeout", 1'b1, 1'b0);
  endtask

  task automatic send_frame(input int len, input int nm_pct, input int bad_keep_at);
    logic [3:0] k;
    bit l;
    frame_id++;
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 99) < nm_pct) begin
        if ($urandom_range(0, 1) == 0)
          send_beat($urandom, $urandom_range(0, 1) == 1, 4'hF, 2'd1, 8'd0);
        else
          send_beat($urandom, $urandom_range(0, 1) == 1, 4'hF, 2'd0, 8'h05);
      end
      l = (i == len - 1);
      k = l ? (($urandom_range(0, 1) == 1) ? 4'hF : 4'h0) : 4'hF;
      if (i == bad_keep_at) k = 4'h3;
      send_beat({frame_id[15:0], 8'h00, i[7:0]} ^ {$urandom_range(0, 255), 24'h0}, l, k,
                2'd0, 8'd0);
    end
  endtask

  initial begin
    int acc_cnt;
    rst = 1'b1; tvalid = 1'b0; tdata = 32'h0; tlast = 1'b0; tkeep = 4'hF;
    tdest = 2'd0; tid = 8'd0; dout_ready = 1'b0; clr_err = 1'b0;
    m_fcnt = 16'd0; m_pos = 0;
    tick(); tick();
    rst = 1'b0;
    idle(2, 1'b1);

    // Three back-to-back good frames with a draining consumer.
    rdy_pct = 100;
    for (int f = 0; f < 3; f++) send_frame(FRAME_LEN, 0, -1);
    idle(4, 1'b1);
    check_eq("three_frames", frame_cnt, 16'd3);

    // Early TLAST, a good frame, then clear.
    send_frame(6, 0, -1);
    send_frame(FRAME_LEN, 0, -1);
    clr_err = 1'b1; idle(1, 1'b1); clr_err = 1'b0;
    check_eq("early_cleared", err_early, 1'b0);

    // Overlong frame enters drain, then a good frame.
    send_frame(13, 0, -1);
    send_frame(FRAME_LEN, 0, -1);
    idle(2, 1'b1);

    // Backpressure: fill, single pop, then push+pop together.
    idle(20, 1'b1);
    acc_cnt = 0;
    tdest = 2'd0; tid = 8'd0; tkeep = 4'hF; tlast = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tvalid = 1'b1; dout_ready = 1'b0; tdata = 32'hB000_0000 + i;
      tick(); if (last_acc) acc_cnt++;
    end
    check_eq("fill_accepts", acc_cnt, 16);
    tvalid = 1'b0; dout_ready = 1'b1; tick();
    acc_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1; dout_ready = 1'b0; tdata = 32'hC000_0000 + i;
      tick(); if (last_acc) acc_cnt++;
    end
    check_eq("pop_then_accept", acc_cnt, 1);
    tvalid = 1'b0; dout_ready = 1'b1;
    for (int i = 0; i < 40 && m_q.size() > 8; i++) tick();
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; dout_ready = 1'b1; tdata = 32'hD000_0000 + i; tick();
    end
    rdy_pct = 100;
    send_beat(32'hD0D0_0000, 1'b1, 4'h0, 2'd0, 8'd0);
    idle(20, 1'b1);

    // Filtering, bad TKEEP, and clear colliding with a new early error.
    clr_err = 1'b1; idle(1, 1'b1); clr_err = 1'b0;
    send_frame(FRAME_LEN, 40, 3);
    idle(2, 1'b1);
    clr_err = 1'b1;
    send_beat(32'hEEEE_0001, 1'b1, 4'hF, 2'd0, 8'd0);
    check_eq("clr_vs_set", err_early, 1'b1);

    // Reset mid-frame with buffered beats.
    idle(20, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tvalid = 1'b1; dout_ready = 1'b0; tdata = 32'hF000_0000 + i;
      tlast = 1'b0; tkeep = 4'hF; tick();
    end
    tvalid = 1'b0; rst = 1'b1; tick();
    check_eq("rst_tready", tready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_valid", dout_valid, 1'b0);
    rst = 1'b0;
    send_frame(FRAME_LEN, 0, -1);
    idle(2, 1'b1);
    check_eq("post_rst_frame", frame_cnt, 16'd1);

    // Randomized traffic.
    rdy_pct = 60;
    for (int f = 0; f < 40; f++) begin
      send_frame(FRAME_LEN + $urandom_range(0, 6) - 3, 15,
                 ($urandom_range(0, 9) == 0) ? 2 : -1);
      if ($urandom_range(0, 7) == 0) begin clr_err = 1'b1; idle(1, 1'b1); clr_err = 1'b0; end
      if ($urandom_range(0, 19) == 0) begin rst = 1'b1; idle(1, 1'b0); rst = 1'b0; end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5), $urandom_range(0, 1) == 1);
    end
    idle(30, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/axi4_stream_rx.md
Name: axi4_stream_rx

Overview:
- AXI4-Stream slave terminating the 32-bit fabric stream; the sink-side counterpart of the framing generator that produces TLAST/TKEEP/TDEST/TID.
- Accepts beats under TREADY backpressure, filters on TDEST/TID, checks frame length against FRAME_LEN, and buffers accepted beats in a first-word-fall-through FIFO for a downstream fabric consumer.
- Maintains a good-frame counter and sticky framing error flags.

Parameters:
- FRAME_LEN, 10, beats per frame; TLAST is expected on beat index FRAME_LEN-1 (minimum 2).
- FIFO_DEPTH, 16, FIFO entries; power of two.
- ADDR_W, 4, log2(FIFO_DEPTH).
- DEST_MATCH, 0, TDEST value accepted (2 bits).
- ID_MATCH, 0, TID value accepted (8 bits).

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- TVALID  in  1  stream beat valid.
- TREADY  out  1  sink ready.
- TDATA  in  32  beat data.
- TLAST  in  1  end of frame.
- TKEEP  in  4  byte qualifiers.
- TDEST  in  2  destination.
- TID  in  8  stream ID.
- DOUT  out  32  FIFO head data.
- DOUT_LAST  out  1  FIFO head TLAST.
- DOUT_VALID  out  1  FIFO not empty.
- DOUT_READY  in  1  consumer pops head when DOUT_VALID is high.
- CLR_ERR  in  1  one-cycle pulse that clears the sticky errors.
- FRAME_CNT  out  16  count of good frames; wraps.
- ERR_EARLY  out  1  sticky: TLAST before beat FRAME_LEN-1.
- ERR_LATE  out  1  sticky: no TLAST on beat FRAME_LEN-1.
- ERR_KEEP  out  1  sticky: TKEEP neither 4'hF nor 4'h0.
- BUSY  out  1  mid-frame (state != IDLE).

Behaviour:
- Reset, sampled on ACLK while RST=1:
  - All outputs 0, including TREADY. TREADY = !RST && (fifo_count != FIFO_DEPTH).
  - FIFO pointers, count, beat counter, state, FRAME_CNT and error flags cleared.
  - Reset mid-frame discards the partial frame and its buffered beats; no error is flagged.
- Accept = TVALID && TREADY. Match = (TDEST==DEST_MATCH) && (TID==ID_MATCH).
- Accepted non-matching beats are dropped: no FIFO write, no beat count, no state change.
- Accepted matching beats:
  - Written as {TLAST, TDATA} to the FIFO regardless of framing errors.
  - ERR_KEEP is set if TKEEP is not 4'hF and not 4'h0.
  - TKEEP=4'h0 (null last beat) is legal and counts as a beat.
- FSM, with beat counter beat_ff (0..FRAME_LEN-1):
  - IDLE (beat_ff=0):
    - matching beat with TLAST: ERR_EARLY, stay IDLE.
    - matching beat without TLAST: beat_ff=1, go to FRAME.
  - FRAME:
    - TLAST with beat_ff<FRAME_LEN-1: ERR_EARLY, beat_ff=0, go to IDLE.
    - TLAST with beat_ff==FRAME_LEN-1: FRAME_CNT+1, beat_ff=0, go to IDLE.
    - no TLAST with beat_ff==FRAME_LEN-1: ERR_LATE, go to DRAIN.
    - otherwise: beat_ff+1.
  - DRAIN: wait for a matching TLAST beat, then beat_ff=0, go to IDLE; no FRAME_CNT increment.
- FRAME_CNT: increments only on good frames; 16'hFFFF+1 wraps to 0.
- Error flags: sticky until CLR_ERR. If CLR_ERR coincides with a new error event, that flag ends set (set wins).
- FIFO (first-word fall-through):
  - DOUT, DOUT_LAST = mem[rd_ptr]; DOUT_VALID = (count != 0).
  - A beat accepted in cycle N is visible on DOUT_VALID in cycle N+1.
  - Simultaneous write and pop: count unchanged, both pointers advance and wrap modulo FIFO_DEPTH.
  - Full: TREADY low. A pop while full raises TREADY in the next cycle; there is no same-cycle pass-through.
  - Pop when empty (DOUT_READY high, DOUT_VALID low) is ignored.
- Latency: TREADY depends only on registered count, so there is no combinational path from TVALID to TREADY.

Test Plan:
- Reset then 3 back-to-back 10-beat frames (TLAST on beat 9, TKEEP=F, last beat TKEEP=0, TDEST=0, TID=0), DOUT_READY=1 -> FRAME_CNT=3, no errors, 30 DOUT beats in order, DOUT_LAST on beats 9/19/29, first DOUT_VALID one cycle after first accept.
- Frame with TLAST on beat 5, then a good frame -> ERR_EARLY=1, FRAME_CNT=1. Pulse CLR_ERR -> ERR_EARLY=0 next cycle.
- 13-beat frame with TLAST on beat 12 -> ERR_LATE=1, BUSY high through beat 12, FRAME_CNT=0; next good frame -> FRAME_CNT=1.
- DOUT_READY=0, 20 beats offered -> TREADY drops after 16 accepts, count=16. Single pop -> TREADY=1 next cycle, one more beat accepted. Simultaneous push and pop at count=8 keeps count at 8.
- Beats with TDEST=1 or TID=8'h05 interleaved in a good frame -> dropped, FRAME_CNT still increments, FIFO holds only matching beats. TKEEP=4'h3 on a beat -> ERR_KEEP=1. CLR_ERR in the same cycle as a new early error -> ERR_EARLY stays 1.
- RST asserted mid-frame at beat 4 with 4 entries buffered -> next cycle TREADY=0, DOUT_VALID=0, BUSY=0, FRAME_CNT=0. After RST release a good frame counts as 1.
